// File: rtl/host_launcher_pkg.sv
// host_launcher_pkg: register map, opcodes, status bits and FSM states shared by the
// launcher and the register-file side.
package host_launcher_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_LEN,
    S_WR_INP_L,
    S_WR_INP_H,
    S_WR_OUT_L,
    S_WR_OUT_H,
    S_WR_LAUNCH,
    S_POLL_REQ,
    S_POLL_WAIT,
    S_POLL_GAP,
    S_WR_CLEAR,
    S_DONE
  } state_e;
  localparam logic [7:0] REG_CTRL  = 8'h00;
  localparam logic [7:0] REG_LEN   = 8'h04;
  localparam logic [7:0] REG_INP_L = 8'h08;
  localparam logic [7:0] REG_INP_H = 8'h0c;
  localparam logic [7:0] REG_OUT_L = 8'h10;
  localparam logic [7:0] REG_OUT_H = 8'h14;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam int STAT_LAUNCH = 0;
  localparam int STAT_FINISH = 1;
endpackage

// File: rtl/host_launcher.sv
// host_launcher: programs a register-mapped accelerator, launches it, polls for finish
// (with optional timeout), clears it and reports the elapsed cycle count.
module host_launcher
  import host_launcher_pkg::*;
#(
  parameter int HOST_ADDR_BITS = 8,
  parameter int HOST_DATA_BITS = 32,
  parameter int POLL_GAP = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [31:0]               job_length,
  input  logic [63:0]               job_inp_baddr,
  input  logic [63:0]               job_out_baddr,
  input  logic [31:0]               timeout_limit,
  output logic                      host_req_valid,
  output logic                      host_req_opcode,
  output logic [HOST_ADDR_BITS-1:0] host_req_addr,
  output logic [HOST_DATA_BITS-1:0] host_req_value,
  input  logic                      host_req_deq,
  input  logic                      host_resp_valid,
  input  logic [HOST_DATA_BITS-1:0] host_resp_bits,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic [31:0]               done_cycles,
  output logic                      done_timeout,
  output logic                      busy
);
  state_e state, state_nx;
  logic [31:0] len_q, lim_q, cnt, gap_cnt, wdata;
  logic [63:0] inp_q, out_q;
  logic [7:0] waddr;
  logic tmo_q, polling, timed_out, finished, resp_unused;
  assign polling = state inside {S_POLL_REQ, S_POLL_WAIT, S_POLL_GAP};
  assign timed_out = lim_q != '0 && cnt >= lim_q;
  assign finished = state == S_POLL_WAIT && host_resp_valid && host_resp_bits[STAT_FINISH];
  assign resp_unused = ^host_resp_bits;
  assign job_ready = reset && state == S_IDLE;
  assign busy = state != S_IDLE;
  assign done_valid = state == S_DONE;
  assign done_cycles = done_valid ? cnt : '0;
  assign done_timeout = done_valid && tmo_q;
  assign host_req_addr = HOST_ADDR_BITS'(waddr);
  assign host_req_value = HOST_DATA_BITS'(wdata);
  // Request fields depend only on state, so they hold until the responder dequeues.
  always_comb begin
    state_nx = state;
    host_req_valid = 1'b1;
    host_req_opcode = OP_WRITE;
    waddr = REG_CTRL;
    wdata = '0;
    case (state)
      S_IDLE: begin
        host_req_valid = 1'b0;
        host_req_opcode = OP_READ;
        state_nx = job_valid ? S_WR_LEN : S_IDLE;
      end
      S_WR_LEN: begin
        waddr = REG_LEN;
        wdata = len_q;
        state_nx = host_req_deq ? S_WR_INP_L : state;
      end
      S_WR_INP_L: begin
        waddr = REG_INP_L;
        wdata = inp_q[31:0];
        state_nx = host_req_deq ? S_WR_INP_H : state;
      end
      S_WR_INP_H: begin
        waddr = REG_INP_H;
        wdata = inp_q[63:32];
        state_nx = host_req_deq ? S_WR_OUT_L : state;
      end
      S_WR_OUT_L: begin
        waddr = REG_OUT_L;
        wdata = out_q[31:0];
        state_nx = host_req_deq ? S_WR_OUT_H : state;
      end
      S_WR_OUT_H: begin
        waddr = REG_OUT_H;
        wdata = out_q[63:32];
        state_nx = host_req_deq ? S_WR_LAUNCH : state;
      end
      S_WR_LAUNCH: begin
        wdata = 32'd1;
        state_nx = host_req_deq ? S_POLL_REQ : state;
      end
      S_POLL_REQ: begin
        host_req_opcode = OP_READ;
        state_nx = host_req_deq ? S_POLL_WAIT : timed_out ? S_WR_CLEAR : state;
      end
      S_POLL_WAIT: begin
        host_req_valid = 1'b0;
        host_req_opcode = OP_READ;
        state_nx = !host_resp_valid ? state : (finished || timed_out) ? S_WR_CLEAR : S_POLL_GAP;
      end
      S_POLL_GAP: begin
        host_req_valid = 1'b0;
        host_req_opcode = OP_READ;
        state_nx = timed_out ? S_WR_CLEAR : gap_cnt == 32'(POLL_GAP - 1) ? S_POLL_REQ : state;
      end
      S_WR_CLEAR: state_nx = host_req_deq ? S_DONE : state;
      S_DONE: begin
        host_req_valid = 1'b0;
        host_req_opcode = OP_READ;
        state_nx = done_ready ? S_IDLE : state;
      end
      default: begin
        host_req_valid = 1'b0;
        host_req_opcode = OP_READ;
        state_nx = S_IDLE;
      end
    endcase
  end
  // The counter stops on the edge into WR_CLEAR so DONE reports the value seen at that decision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      len_q <= '0;
      lim_q <= '0;
      inp_q <= '0;
      out_q <= '0;
      cnt <= '0;
      gap_cnt <= '0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && job_valid) begin
        len_q <= job_length;
        lim_q <= timeout_limit;
        inp_q <= job_inp_baddr;
        out_q <= job_out_baddr;
      end
      if (state == S_WR_LAUNCH && host_req_deq) cnt <= '0;
      else if (polling && state_nx != S_WR_CLEAR && cnt != '1) cnt <= cnt + 32'd1;
      gap_cnt <= state == S_POLL_GAP ? gap_cnt + 32'd1 : '0;
      if (polling && state_nx == S_WR_CLEAR) tmo_q <= !finished;
    end
  end
endmodule

// File: doc/host_launcher.md
HOST_LAUNCHER -- requirements
Module: host_launcher

Interface
REQ-001 SHALL have parameter HOST_ADDR_BITS, default 8, host address width.
REQ-002 SHALL have parameter HOST_DATA_BITS, default 32, host data width.
REQ-003 SHALL have parameter POLL_GAP, default 16, idle cycles between status polls (>=1).
REQ-004 SHALL have ports:
 clock  in  1  sole clock
 reset  in  1  asynchronous, active-low reset
 job_valid  in  1  job descriptor offered
 job_ready  out  1  descriptor accepted when job_valid&job_ready
 job_length  in  32  element count
 job_inp_baddr  in  64  input base address
 job_out_baddr  in  64  output base address
 timeout_limit  in  32  max poll-phase cycles; 0 = no timeout
 host_req_valid  out  1  request presented
 host_req_opcode  out  1  1 = write, 0 = read
 host_req_addr  out  HOST_ADDR_BITS  register address
 host_req_value  out  HOST_DATA_BITS  write data (0 on reads)
 host_req_deq  in  1  responder accepted request this cycle
 host_resp_valid  in  1  read data valid
 host_resp_bits  in  HOST_DATA_BITS  read data
 done_valid  out  1  job result available
 done_ready  in  1  result consumed
 done_cycles  out  32  cycles from launch accept to finish seen
 done_timeout  out  1  job ended by timeout
 busy  out  1  state != IDLE

Function
REQ-005 SHALL, in IDLE, drive job_ready=1; on handshake, latch descriptor and timeout_limit, go to WR_LEN next cycle.
REQ-006 SHALL issue writes in order: WR_LEN 0x04=length; WR_INP_L 0x08=inp[31:0]; WR_INP_H 0x0c=inp[63:32]; WR_OUT_L 0x10=out[31:0]; WR_OUT_H 0x14=out[63:32]; WR_LAUNCH 0x00=1.
REQ-007 SHALL hold host_req_valid/opcode/addr/value stable until the cycle host_req_deq=1, then advance state the next cycle; one request per state.
REQ-008 SHALL clear and start a 32-bit saturating cycle counter in the cycle after WR_LAUNCH is dequeued; counter increments every cycle until DONE.
REQ-009 SHALL in POLL_REQ issue read of 0x00; on deq go to POLL_WAIT with host_req_valid=0.
REQ-010 SHALL in POLL_WAIT ignore everything until host_resp_valid; if host_resp_bits[1]=1 go to WR_CLEAR, else to POLL_GAP.
REQ-011 SHALL stay in POLL_GAP exactly POLL_GAP cycles, then return to POLL_REQ.
REQ-012 SHALL, when timeout_limit!=0 and counter reaches timeout_limit in POLL_REQ (before deq), POLL_GAP, or POLL_WAIT (after response), set timeout flag and go to WR_CLEAR; a read already dequeued SHALL complete first.
REQ-013 SHALL in WR_CLEAR write 0x00=0, then enter DONE.
REQ-014 SHALL in DONE drive done_valid=1, done_cycles=counter value frozen at WR_CLEAR entry, done_timeout=flag; hold until done_ready, then IDLE.
REQ-015 SHALL ignore host_resp_valid outside POLL_WAIT; never have more than one outstanding read.
REQ-016 SHALL allow job_valid and done_ready asserted simultaneously without effect outside their states (no descriptor accepted in DONE).

Reset
REQ-017 SHALL on reset low asynchronously enter IDLE, with host_req_valid=0, host_req_opcode=0, host_req_addr=0, host_req_value=0, done_valid=0, done_cycles=0, done_timeout=0, busy=0, job_ready=0 while asserted and 1 after release.
REQ-018 SHALL, on reset mid-job, abandon the sequence without issuing the clear write; responder state is the system's responsibility.

Structure
REQ-019 SHALL place the state enum, register address constants (0x00-0x14), opcode constants and status bit indices (launch=0, finish=1) in shared package host_launcher_pkg, shared with the register-file side.
REQ-020 SHALL be one module without sub-modules; counter and FSM inline.

Verification
REQ-021 Job length=256, inp=0x1_0000_1000, out=0x2_0000_2000, deq always 1 -> writes 0x04=256, 0x08=0x1000, 0x0c=1, 0x10=0x2000, 0x14=2, 0x00=1 on consecutive cycles.
REQ-022 Responder returns status 0 twice then 2 -> exactly 3 reads separated by POLL_GAP idle cycles, clear write 0x00=0, done_timeout=0, done_cycles matches cycle count.
REQ-023 deq held 0 for 5 cycles on WR_INP_H -> request fields stable all 5 cycles, single write issued.
REQ-024 timeout_limit=40, status never finishes -> done_timeout=1, done_cycles=40, clear write issued, no further reads.
REQ-025 done_ready=0 for 10 cycles -> done_valid and outputs held, job_ready=0; reset mid-POLL_WAIT -> all outputs at reset values immediately.
